// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM plus a 16-byte MMIO window (console TX FIFO, cycle counter, TOHOST halt).
// Latency: reads are combinational (0 cycles); writes, FIFO pushes and register updates commit at the rising edge.
// Backpressure: the console FIFO drains on con_valid_o && con_ready_i; a push into a full FIFO with no pop is dropped and sets OVERFLOW.
//
// Ports:
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   mem_rd_addr_i / mem_rd_data_o   combinational read port
//   mem_wr_addr_i / mem_wr_data_i / mem_wr_enable_i   clocked write port
//   con_data_o / con_valid_o / con_ready_i            console byte stream
//   halt_o / tohost_o               sticky halt flag and latched TOHOST value
module mem_responder #(
   parameter int          MEM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] mem_rd_addr_i,
   output logic [31:0] mem_rd_data_o,
   input  logic [31:0] mem_wr_addr_i,
   input  logic [31:0] mem_wr_data_i,
   input  logic        mem_wr_enable_i,
   output logic [7:0]  con_data_o,
   output logic        con_valid_o,
   input  logic        con_ready_i,
   output logic        halt_o,
   output logic [31:0] tohost_o
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] REG_CONSOLE = 2'd0;
   localparam logic [1:0] REG_CYCLE   = 2'd1;
   localparam logic [1:0] REG_TOHOST  = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   // ---------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------
   logic [31:0] ram [MEM_WORDS];
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [31:0] cycle_cnt;
   logic        overflow;

   // ---------------------------------------------------------------
   // Address decode (independent for each port)
   // ---------------------------------------------------------------
   logic          rd_ram, rd_mmio, wr_ram, wr_mmio;
   logic [AW-1:0] rd_idx, wr_idx;
   logic [1:0]    rd_reg, wr_reg;

   // RAM occupies byte addresses [0, MEM_WORDS*4): every bit above the index must be zero.
   assign rd_ram  = (mem_rd_addr_i[31:AW+2] == '0);
   assign wr_ram  = (mem_wr_addr_i[31:AW+2] == '0);
   assign rd_mmio = (mem_rd_addr_i[31:4] == MMIO_BASE[31:4]);
   assign wr_mmio = (mem_wr_addr_i[31:4] == MMIO_BASE[31:4]);
   assign rd_idx  = mem_rd_addr_i[AW+1:2];
   assign wr_idx  = mem_wr_addr_i[AW+1:2];
   assign rd_reg  = mem_rd_addr_i[3:2];
   assign wr_reg  = mem_wr_addr_i[3:2];

   // Byte-offset bits are ignored on both ports.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_rd_addr_i[1:0], mem_wr_addr_i[1:0]};

   // ---------------------------------------------------------------
   // Console FIFO status
   // ---------------------------------------------------------------
   logic [PW:0] fifo_count;
   logic        fifo_empty, fifo_full;
   logic        pop, push_req, push, ovf_set;

   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   // Full when the pointers address the same slot but differ in the wrap bit.
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   assign con_valid_o = !fifo_empty;
   assign con_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];

   // No pops or writes take effect while reset is held.
   assign pop      = rst_n_i && con_valid_o && con_ready_i;
   assign push_req = rst_n_i && mem_wr_enable_i && wr_mmio && (wr_reg == REG_CONSOLE);
   // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
   assign push     = push_req && (!fifo_full || pop);
   assign ovf_set  = push_req && fifo_full && !pop;

   // ---------------------------------------------------------------
   // Read mux (combinational, reflects pre-edge state)
   // ---------------------------------------------------------------
   logic [31:0] console_stat;
   assign console_stat = {16'h0000, 8'(fifo_count), 6'b000000, fifo_full, fifo_empty};

   always_comb begin
      mem_rd_data_o = 32'h0;
      if (rd_ram) begin
         mem_rd_data_o = ram[rd_idx];
      end else if (rd_mmio) begin
         case (rd_reg)
            REG_CONSOLE: mem_rd_data_o = console_stat;
            REG_CYCLE:   mem_rd_data_o = cycle_cnt;
            REG_TOHOST:  mem_rd_data_o = tohost_o;
            default:     mem_rd_data_o = {31'h0, overflow};
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Unreset storage: RAM words and FIFO slots
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_n_i && mem_wr_enable_i && wr_ram) begin
         ram[wr_idx] <= mem_wr_data_i;
      end
      if (push) begin
         fifo_mem[wr_ptr[PW-1:0]] <= mem_wr_data_i[7:0];
      end
   end

   // ---------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cycle_cnt <= 32'h0;
         overflow  <= 1'b0;
         halt_o    <= 1'b0;
         tohost_o  <= 32'h0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         // A software load takes priority over the free-running increment.
         if (mem_wr_enable_i && wr_mmio && wr_reg == REG_CYCLE) begin
            cycle_cnt <= mem_wr_data_i;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end

         if (mem_wr_enable_i && wr_mmio && wr_reg == REG_STATUS) begin
            overflow <= 1'b0;
         end else if (ovf_set) begin
            overflow <= 1'b1;
         end

         // Once halted, TOHOST is frozen until reset.
         if (mem_wr_enable_i && wr_mmio && wr_reg == REG_TOHOST && !halt_o) begin
            tohost_o <= mem_wr_data_i;
            if (mem_wr_data_i != 32'h0) halt_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam logic [31:0] MMIO    = 32'hFFFF_0000;
   localparam logic [31:0] A_CONS  = MMIO + 32'h0;
   localparam logic [31:0] A_CYC   = MMIO + 32'h4;
   localparam logic [31:0] A_HOST  = MMIO + 32'h8;
   localparam logic [31:0] A_STAT  = MMIO + 32'hC;

   logic        clk;
   logic        rst_n;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_en;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready;
   logic        halt;
   logic [31:0] tohost;

   int tests = 0;
   int fails = 0;

   // Scoreboard of console bytes: pushed when a CONSOLE write is driven, popped as bytes drain.
   logic [7:0] byte_q[$];

   mem_responder #(
      .MEM_WORDS (1024),
      .FIFO_DEPTH(8),
      .MMIO_BASE (MMIO)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .mem_rd_addr_i  (rd_addr),
      .mem_rd_data_o  (rd_data),
      .mem_wr_addr_i  (wr_addr),
      .mem_wr_data_i  (wr_data),
      .mem_wr_enable_i(wr_en),
      .con_data_o     (con_data),
      .con_valid_o    (con_valid),
      .con_ready_i    (con_ready),
      .halt_o         (halt),
      .tohost_o       (tohost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      rd_addr = addr;
      #1;
      chk(tag, rd_data, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      wr_addr = addr;
      wr_data = data;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic con_push(input logic [7:0] b, input bit accepted);
      if (accepted) byte_q.push_back(b);
      wr(A_CONS, {24'h0, b});
   endtask

   // Drains n bytes on consecutive cycles, checking each against the scoreboard.
   task automatic drain(input string tag, input int n);
      logic [7:0] exp;
      con_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (byte_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            exp = byte_q.pop_front();
            chk({tag, "_vld"}, {31'h0, con_valid}, 32'd1);
            chk({tag, "_dat"}, {24'h0, con_data}, {24'h0, exp});
         end
         tick();
      end
      con_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      rd_addr   = 32'h0;
      wr_addr   = 32'h0;
      wr_data   = 32'h0;
      wr_en     = 1'b0;
      con_ready = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_valid", {31'h0, con_valid}, 32'd0);
      chk("rst_data", {24'h0, con_data}, 32'd0);
      chk("rst_halt", {31'h0, halt}, 32'd0);
      chk("rst_tohost", tohost, 32'd0);
      rd("rst_cycle", A_CYC, 32'd0);
      rd("rst_status", A_STAT, 32'd0);
      rd("rst_console", A_CONS, 32'h0000_0001);

      // Counter: first cycle with reset high is cycle 0
      rst_n = 1'b1;
      repeat (5) tick();
      rd("cycle_at5", A_CYC, 32'd5);
      wr(A_CYC, 32'hFFFF_FFFE);
      rd("cycle_load", A_CYC, 32'hFFFF_FFFE);
      tick();
      rd("cycle_max", A_CYC, 32'hFFFF_FFFF);
      tick();
      rd("cycle_wrap", A_CYC, 32'h0);

      // RAM round-trip with same-cycle read-old behaviour
      wr(32'h10, 32'h1111_1111);
      wr_addr = 32'h10;
      wr_data = 32'hDEAD_BEEF;
      wr_en   = 1'b1;
      rd("ram_same_cycle", 32'h10, 32'h1111_1111);
      tick();
      wr_en = 1'b0;
      rd("ram_10", 32'h10, 32'hDEAD_BEEF);
      rd("ram_11", 32'h11, 32'hDEAD_BEEF);
      rd("ram_13", 32'h13, 32'hDEAD_BEEF);

      // Unmapped address: write dropped, no aliasing onto RAM index 0
      wr(32'h0, 32'hCAFE_F00D);
      wr(32'h8000_0000, 32'h1234_5678);
      rd("unmapped_rd", 32'h8000_0000, 32'h0);
      rd("ram0_intact", 32'h0, 32'hCAFE_F00D);

      // FIFO fill beyond capacity: 'A'..'H' accepted, 'I' overflows
      for (int i = 0; i < 9; i++) con_push(8'h41 + 8'(i), i < 8);
      rd("fill_console", A_CONS, 32'h0000_0802);
      rd("fill_status", A_STAT, 32'h1);
      drain("drain1", 8);
      chk("drain1_empty", {31'h0, con_valid}, 32'd0);
      chk("drain1_data0", {24'h0, con_data}, 32'd0);
      rd("drain1_console", A_CONS, 32'h0000_0001);
      rd("ovf_sticky", A_STAT, 32'h1);
      wr(A_STAT, 32'h0);
      rd("ovf_clear", A_STAT, 32'h0);

      // Simultaneous push and pop while full
      for (int i = 0; i < 8; i++) con_push(8'h61 + 8'(i), 1'b1);
      rd("full2_console", A_CONS, 32'h0000_0802);
      con_ready = 1'b1;
      chk("pp_head", {24'h0, con_data}, {24'h0, byte_q.pop_front()});
      con_push(8'h5A, 1'b1);
      con_ready = 1'b0;
      rd("pp_console", A_CONS, 32'h0000_0802);
      rd("pp_status", A_STAT, 32'h0);
      drain("drain2", 8);
      chk("drain2_empty", {31'h0, con_valid}, 32'd0);

      // TOHOST / halt
      wr(A_HOST, 32'h0);
      chk("host0_halt", {31'h0, halt}, 32'd0);
      wr(A_HOST, 32'h1);
      chk("host1_halt", {31'h0, halt}, 32'd1);
      chk("host1_val", tohost, 32'd1);
      wr(A_HOST, 32'h7);
      chk("host7_ignored", tohost, 32'd1);
      rd("host_rd", A_HOST, 32'd1);

      // Reset mid-operation: FIFO and halt cleared, RAM kept, writes ignored
      con_push(8'h51, 1'b1);
      chk("pre_rst_valid", {31'h0, con_valid}, 32'd1);
      rst_n = 1'b0;
      wr(32'h10, 32'h0);
      rst_n = 1'b1;
      byte_q.delete();
      chk("rst2_halt", {31'h0, halt}, 32'd0);
      chk("rst2_tohost", tohost, 32'd0);
      chk("rst2_valid", {31'h0, con_valid}, 32'd0);
      chk("rst2_data", {24'h0, con_data}, 32'd0);
      rd("rst2_ram", 32'h10, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's memory port. It serves combinational instruction/data reads and clocked writes from a word-organised RAM, plus a small MMIO window. The MMIO window holds a console TX FIFO with a valid/ready drain, a free-running cycle counter, and a TOHOST halt register. It sits at the top level opposite the datapath and is the only slave on that port.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- FIFO_DEPTH, 8: console FIFO entries; must be a power of two, ≥2, ≤128.
- MMIO_BASE, 32'hFFFF_0000: base byte address of the 16-byte MMIO window.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- mem_rd_addr_i  in  32  read byte address; bits [1:0] ignored.
- mem_rd_data_o  out  32  read data, combinational from mem_rd_addr_i.
- mem_wr_addr_i  in  32  write byte address; bits [1:0] ignored.
- mem_wr_data_i  in  32  write data.
- mem_wr_enable_i  in  1  write strobe; the write is sampled at the rising edge.
- con_data_o  out  8  console FIFO head byte; 8'h00 when the FIFO is empty.
- con_valid_o  out  1  FIFO non-empty.
- con_ready_i  in  1  sink accepts con_data_o when con_valid_o is high.
- halt_o  out  1  sticky; set by a nonzero TOHOST write.
- tohost_o  out  32  latched TOHOST value.

## Operation
- Address decode applies to the read and write ports independently, using the word address a = addr[31:2].
  - RAM: addr < MEM_WORDS*4. The RAM index is a[log2(MEM_WORDS)-1:0].
  - MMIO: addr[31:4] == MMIO_BASE[31:4]. The register is selected by addr[3:2].
  - Anything else: reads return 32'h0 and writes are dropped.
- RAM: contents are not reset. Reads are asynchronous. Writes are a full word, committed at the edge.
- MMIO registers, by offset:
  - 0x0 CONSOLE, write: push mem_wr_data_i[7:0] if the FIFO is not full. If the FIFO is full, the byte is dropped and OVERFLOW is set.
  - 0x0 CONSOLE, read: bit 0 is empty, bit 1 is full, bits [15:8] are the occupancy count zero-extended. All other bits read 0.
  - 0x4 CYCLE, read: 32-bit counter.
  - 0x4 CYCLE, write: loads the counter. The load wins over the increment.
  - 0x8 TOHOST, read: tohost_o.
  - 0x8 TOHOST, write (only while halt_o is 0): tohost_o <= data. If data != 0, halt_o <= 1. Writes while halted are ignored.
  - 0xC STATUS, read: bit 0 is OVERFLOW, all other bits 0.
  - 0xC STATUS, write: any write clears OVERFLOW.
- Console FIFO: a circular buffer with read/write pointers of width log2(FIFO_DEPTH)+1 (wrap bit).
  - Pop occurs when con_valid_o && con_ready_i.
  - Push and pop in the same cycle: both happen and the count is unchanged. This holds even when the FIFO is full, where the push is accepted, not dropped.
  - Push into an empty FIFO: con_valid_o rises the next cycle. There is no fall-through.
- Cycle counter: increments by 1 every cycle out of reset and wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset (rst_n_i low at an edge) sets:
  - FIFO empty: con_valid_o=0, con_data_o=8'h00.
  - Counter = 0, OVERFLOW = 0, halt_o = 0, tohost_o = 0.
- While rst_n_i is low:
  - Writes are ignored and no pop occurs.
  - mem_rd_data_o still returns RAM contents and MMIO reset values.
- Read latency: 0 cycles, combinational.
- Read and write to the same address in the same cycle: the read returns the old value. The new value is visible from the next cycle.
- CYCLE read value in cycle N after reset deassert = N, where the first cycle with rst_n_i high is N=0.
- A CYCLE write of V at edge E: reads after E return V, then V+1, and so on.
- FIFO status and OVERFLOW update at the edge. CONSOLE reads reflect pre-edge state.
- Reset mid-operation discards FIFO contents and the halt state. RAM is untouched.

## Test plan
- RAM round-trip: write 32'hDEADBEEF to 0x10, then read 0x10, 0x11 and 0x13 next cycle -> all return 32'hDEADBEEF. A same-cycle read returns the old value.
- Unmapped address: write to 0x8000_0000 (MEM_WORDS=1024), then read it -> 32'h0, and RAM index 0 is unchanged.
- FIFO boundaries (FIFO_DEPTH=8, con_ready_i=0):
  - Push 'A'..'I' -> CONSOLE reads 32'h0802 and STATUS reads 1.
  - Raise con_ready_i -> 'A'..'H' drain on consecutive cycles, then con_valid_o=0 and CONSOLE reads 32'h0001.
- Simultaneous full push/pop: FIFO full, con_ready_i=1 and a push of 'Z' in the same cycle -> count stays 8, OVERFLOW stays 0, and 'Z' emerges as the 8th byte after.
- Counter: after reset, read CYCLE at cycle 5 -> 5. Write 32'hFFFF_FFFE -> the next two reads are 32'hFFFF_FFFE and 32'hFFFF_FFFF, then 0.
- Halt and reset:
  - Write 0 to TOHOST -> halt_o stays 0.
  - Write 1 -> halt_o=1, tohost_o=1. A later write of 7 is ignored.
  - Assert rst_n_i=0 for one edge -> halt_o=0, tohost_o=0, FIFO empty.
